pc_sequencer: RTL and testbench

Program-counter stage that sits directly upstream of instruction_fetch. It owns the architectural PC register and drives the fetch address each cycle. It selects the next PC from sequential increment or a resolved branch target. It also stops the machine on the halt opcode or on a misaligned target, and keeps cycle and retired-instruction counters for the bench.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 21 ++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared opcode constants, PC sequencer state encoding and PC increment step.
package riscv_pkg;

    localparam logic [6:0] OPC_HALT   = 7'b1111111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential increment or pc-relative branch target.
module pc_next_calc
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] target;

    // Both sums wrap modulo 2^ADDR_W by construction.
    assign target     = pc + branch_offset;
    assign next_pc    = branch_taken ? target : pc + ADDR_W'(PC_INC);
    assign misaligned = branch_taken && (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the fetch PC, stops on halt or misaligned branch, counts cycles/retires.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32,
    parameter logic [6:0]        HALT_OPC = OPC_HALT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              error,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    pc_state_e         state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic              halted_d, error_d;
    logic [CNT_W-1:0]  cycle_d, instr_d;
    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;

    // Only the opcode field matters to this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[31:7];

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            halted    <= 1'b0;
            error     <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            halted    <= halted_d;
            error     <= error_d;
            cycle_cnt <= cycle_d;
            instr_cnt <= instr_d;
        end
    end

    // Priority in RUN: halt, stall, branch (with alignment check), sequential.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        halted_d = halted;
        error_d  = error;
        cycle_d  = cycle_cnt;
        instr_d  = instr_cnt;
        case (state)
            RUN: begin
                if (cycle_cnt != '1) begin
                    cycle_d = cycle_cnt + CNT_W'(1);
                end
                if (instruction[6:0] == HALT_OPC) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else if (!stall) begin
                    if (misaligned) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                        if (instr_cnt != '1) begin
                            instr_d = instr_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checking of pc_sequencer against a behavioural PC model.
module tb_pc_sequencer;
    import riscv_pkg::*;

    localparam logic [31:0] INSTR_ADD  = 32'b0000000_00010_00001_000_00011_0110011;
    localparam logic [31:0] INSTR_HALT = 32'b0000000_00001_00010_101_00100_1111111;
    localparam logic [31:0] INSTR_BR   = 32'b0000000_00010_00001_000_00000_1100011;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] pc;
    logic        halted;
    logic        error;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt, m_err;
    logic [31:0] m_cyc, m_ins;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction   (instruction),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc            (pc),
        .halted        (halted),
        .error         (error),
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},     64'(pc),        64'(m_pc));
        check({tag, ".halted"}, 64'(halted),    64'(m_halt));
        check({tag, ".error"},  64'(error),     64'(m_err));
        check({tag, ".cyc"},    64'(cycle_cnt), 64'(m_cyc));
        check({tag, ".ins"},    64'(instr_cnt), 64'(m_ins));
        check({tag, ".excl"},   64'(halted & error), 64'(0));
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Apply the architectural rules for one clock edge using the current inputs.
    task automatic model_edge();
        logic [31:0] tgt;
        if (m_halt || m_err) return;
        m_cyc = sat_inc(m_cyc);
        if (instruction[6:0] == OPC_HALT) begin
            m_halt = 1;
        end else if (stall) begin
            // hold
        end else if (branch_taken) begin
            tgt = m_pc + branch_offset;
            if (tgt % 4 != 0) m_err = 1;
            else begin
                m_pc  = tgt;
                m_ins = sat_inc(m_ins);
            end
        end else begin
            m_pc  = m_pc + 32'd4;
            m_ins = sat_inc(m_ins);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Called between edges; checks that reset acts without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_pc = 32'h0; m_halt = 0; m_err = 0; m_cyc = 32'h0; m_ins = 32'h0;
        check_all("rst");
        check("rst_pc_const", 64'(pc), 64'(0));
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic [31:0] ins, input logic stl, input logic br,
                          input logic [31:0] off);
        instruction   = ins;
        stall         = stl;
        branch_taken  = br;
        branch_offset = off;
    endtask

    initial begin
        logic [31:0] tmp;
        logic [6:0]  opc;
        int          r;
        logic [31:0] cyc_before;

        rst_n = 1'b0;
        set_in(INSTR_ADD, 0, 0, 32'h0);
        #1;
        do_reset();

        // Sequential run up to a halt at pc=32
        for (int i = 0; i < 3; i++) step("seq");
        check("seq3_pc",  64'(pc), 64'(12));
        check("seq3_ins", 64'(instr_cnt), 64'(3));
        check("seq3_cyc", 64'(cycle_cnt), 64'(3));
        for (int i = 0; i < 5; i++) step("seq");
        set_in(INSTR_HALT, 0, 0, 32'h0);
        step("halt");
        check("halt_pc",  64'(pc), 64'(32));
        check("halt_flg", 64'(halted), 64'(1));
        check("halt_ins", 64'(instr_cnt), 64'(8));
        set_in(INSTR_ADD, 0, 1, 32'h4);
        for (int i = 0; i < 5; i++) step("halt_hold");
        check("halt_hold_cyc", 64'(cycle_cnt), 64'(9));

        // Forward and backward branches, stall holding a pending branch
        #1 do_reset();
        set_in(INSTR_BR, 0, 1, 32'd12);
        step("br_fwd");
        check("br_fwd_pc", 64'(pc), 64'(12));
        set_in(INSTR_ADD, 0, 0, 32'h0);
        step("br_seq");
        set_in(INSTR_BR, 0, 1, 32'hFFFF_FFF8);
        step("br_back");
        check("br_back_pc", 64'(pc), 64'(8));
        check("br_back_ins", 64'(instr_cnt), 64'(3));
        cyc_before = cycle_cnt;
        set_in(INSTR_BR, 1, 1, 32'd8);
        step("stall");
        step("stall");
        check("stall_pc",  64'(pc), 64'(8));
        check("stall_cyc", 64'(cycle_cnt), 64'(cyc_before + 32'd2));
        stall = 1'b0;
        step("stall_rel");
        check("stall_rel_pc", 64'(pc), 64'(16));

        // Misaligned branch target goes to ERROR
        #1 do_reset();
        set_in(INSTR_ADD, 0, 0, 32'h0);
        step("mis_seq");
        set_in(INSTR_BR, 0, 1, 32'd6);
        step("mis");
        check("mis_err", 64'(error), 64'(1));
        check("mis_pc",  64'(pc), 64'(4));
        check("mis_hlt", 64'(halted), 64'(0));
        set_in(INSTR_ADD, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("mis_hold");

        // Self-loop with zero offset, then wrap through all-ones-minus-3
        #1 do_reset();
        set_in(INSTR_BR, 0, 1, 32'h0);
        step("self");
        check("self_pc",  64'(pc), 64'(0));
        check("self_ins", 64'(instr_cnt), 64'(1));
        set_in(INSTR_BR, 0, 1, 32'hFFFF_FFFC);
        step("to_top");
        set_in(INSTR_ADD, 0, 0, 32'h0);
        step("wrap");
        check("wrap_pc", 64'(pc), 64'(0));

        // Asynchronous reset mid-run
        #1 do_reset();
        for (int i = 0; i < 5; i++) step("pre_rst");
        check("pre_rst_pc", 64'(pc), 64'(20));
        #3 do_reset();
        check("mid_rst_cyc", 64'(cycle_cnt), 64'(0));
        check("mid_rst_ins", 64'(instr_cnt), 64'(0));
        step("post_rst");
        check("post_rst_pc", 64'(pc), 64'(4));

        // Halt beats stall
        set_in(INSTR_HALT, 1, 1, 32'd8);
        step("halt_stall");
        check("halt_stall_flg", 64'(halted), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halt || m_err) && $urandom_range(0, 7) == 0) begin
                #1 do_reset();
            end
            r = int'($urandom_range(0, 99));
            opc = (r < 3) ? OPC_HALT : (r < 45) ? OPC_BRANCH : OPC_RTYPE;
            tmp = $urandom;
            instruction  = {tmp[31:7], opc};
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = (opc == OPC_BRANCH) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) branch_offset = $urandom;
            else branch_offset = 32'((int'($urandom_range(0, 63)) - 32) * 4);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
